// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard/stall scheduler: forwarding selects, FSM states
// and the producer-match helper used by the forwarding comparators.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_ALU = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam int unsigned MEM_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLuStall,
    StMemWait,
    StAbort
  } hz_state_e;

  // x0 is hard-wired zero, so it never has a producer to forward from.
  function automatic logic src_hit(logic [4:0] src, logic [4:0] rd, logic rd_w_en,
                                   logic clk_en);
    return (src != 5'd0) && (src == rd) && rd_w_en && clk_en;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// Single-source priority comparator against the ALU, Mem and WB producers.
// Reports the forwarding select, or a hazard when the youngest producer is not ready.
module hazard_ctrl_fwd_match
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       src_en,
  input  logic [4:0] alu_rd,
  input  logic       alu_rd_w_en,
  input  logic       alu_clk_en,
  input  logic       alu_rd_valid,
  input  logic [4:0] mem_rd,
  input  logic       mem_rd_w_en,
  input  logic       mem_clk_en,
  input  logic       mem_rd_valid,
  input  logic [4:0] wb_rd,
  input  logic       wb_rd_w_en,
  input  logic       wb_clk_en,
  output logic [1:0] sel,
  output logic       hazard
);

  logic alu_hit, mem_hit, wb_hit;

  always_comb begin
    alu_hit = src_en && src_hit(src, alu_rd, alu_rd_w_en, alu_clk_en);
    mem_hit = src_en && src_hit(src, mem_rd, mem_rd_w_en, mem_clk_en);
    wb_hit  = src_en && src_hit(src, wb_rd, wb_rd_w_en, wb_clk_en);
  end

  // Youngest producer wins; an unready producer masks older ones and reads regfile.
  always_comb begin
    sel    = FWD_RF;
    hazard = 1'b0;
    if (alu_hit) begin
      if (alu_rd_valid) sel = FWD_ALU;
      else              hazard = 1'b1;
    end else if (mem_hit) begin
      if (mem_rd_valid) sel = FWD_MEM;
      else              hazard = 1'b1;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall scheduler: load-use/CSR-use stalls, operand forwarding
// selects and the Mem-stage data-memory wait with bounded timeout.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_valid,
  input  logic [4:0] dec_rs1,
  input  logic [4:0] dec_rs2,
  input  logic       dec_use_rs2,
  input  logic       alu_clk_en,
  input  logic [4:0] alu_rd,
  input  logic       alu_rd_w_en,
  input  logic       alu_rd_valid,
  input  logic       alu_mem_req,
  input  logic       mem_clk_en,
  input  logic [4:0] mem_rd,
  input  logic       mem_rd_w_en,
  input  logic       mem_rd_valid,
  input  logic       wb_clk_en,
  input  logic [4:0] wb_rd,
  input  logic       wb_rd_w_en,
  input  logic       dmem_ack,
  input  logic       flush_in,
  output logic       force_stall,
  output logic       mem_stall,
  output logic [1:0] fwd_rs1_sel,
  output logic [1:0] fwd_rs2_sel,
  output logic       bus_timeout,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MEM_TIMEOUT - 1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [1:0] rs1_sel, rs2_sel;
  logic       rs1_hz, rs2_hz, lu_hz;

  hazard_ctrl_fwd_match u_match_rs1 (
    .src          (dec_rs1),
    .src_en       (1'b1),
    .alu_rd       (alu_rd),
    .alu_rd_w_en  (alu_rd_w_en),
    .alu_clk_en   (alu_clk_en),
    .alu_rd_valid (alu_rd_valid),
    .mem_rd       (mem_rd),
    .mem_rd_w_en  (mem_rd_w_en),
    .mem_clk_en   (mem_clk_en),
    .mem_rd_valid (mem_rd_valid),
    .wb_rd        (wb_rd),
    .wb_rd_w_en   (wb_rd_w_en),
    .wb_clk_en    (wb_clk_en),
    .sel          (rs1_sel),
    .hazard       (rs1_hz)
  );

  hazard_ctrl_fwd_match u_match_rs2 (
    .src          (dec_rs2),
    .src_en       (dec_use_rs2),
    .alu_rd       (alu_rd),
    .alu_rd_w_en  (alu_rd_w_en),
    .alu_clk_en   (alu_clk_en),
    .alu_rd_valid (alu_rd_valid),
    .mem_rd       (mem_rd),
    .mem_rd_w_en  (mem_rd_w_en),
    .mem_clk_en   (mem_clk_en),
    .mem_rd_valid (mem_rd_valid),
    .wb_rd        (wb_rd),
    .wb_rd_w_en   (wb_rd_w_en),
    .wb_clk_en    (wb_clk_en),
    .sel          (rs2_sel),
    .hazard       (rs2_hz)
  );

  assign lu_hz = dec_valid && (rs1_hz || rs2_hz);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (alu_mem_req && alu_clk_en) begin
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end else if (lu_hz) begin
          state_d = StLuStall;
        end
      end
      StLuStall: begin
        if (flush_in || !lu_hz) state_d = StIdle;
      end
      // Flush is deliberately ignored here: the bus transaction must complete.
      StMemWait: begin
        if (dmem_ack) begin
          state_d = StIdle;
        end else if (wait_cnt_q == CntLast) begin
          state_d = StAbort;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // A flush kills the decode instruction, so its stall is released in the same cycle.
  always_comb begin
    force_stall = !rst && lu_hz && !flush_in;
    mem_stall   = !rst && (state_q == StMemWait) && !dmem_ack;
    bus_timeout = !rst && (state_q == StAbort);
    busy        = !rst && (state_q != StIdle);
    fwd_rs1_sel = rst ? FWD_RF : rs1_sel;
    fwd_rs2_sel = rst ? FWD_RF : rs2_sel;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a flag-based behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid, dec_use_rs2;
  logic [4:0] dec_rs1, dec_rs2;
  logic       alu_clk_en, alu_rd_w_en, alu_rd_valid, alu_mem_req;
  logic [4:0] alu_rd, mem_rd, wb_rd;
  logic       mem_clk_en, mem_rd_w_en, mem_rd_valid;
  logic       wb_clk_en, wb_rd_w_en;
  logic       dmem_ack, flush_in;
  logic       force_stall, mem_stall, bus_timeout, busy;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which activity is pending and how long the memory access has waited.
  bit m_waiting, m_aborting, m_lu;
  int m_waited;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_use_rs2  (dec_use_rs2),
    .alu_clk_en   (alu_clk_en),
    .alu_rd       (alu_rd),
    .alu_rd_w_en  (alu_rd_w_en),
    .alu_rd_valid (alu_rd_valid),
    .alu_mem_req  (alu_mem_req),
    .mem_clk_en   (mem_clk_en),
    .mem_rd       (mem_rd),
    .mem_rd_w_en  (mem_rd_w_en),
    .mem_rd_valid (mem_rd_valid),
    .wb_clk_en    (wb_clk_en),
    .wb_rd        (wb_rd),
    .wb_rd_w_en   (wb_rd_w_en),
    .dmem_ack     (dmem_ack),
    .flush_in     (flush_in),
    .force_stall  (force_stall),
    .mem_stall    (mem_stall),
    .fwd_rs1_sel  (fwd_rs1_sel),
    .fwd_rs2_sel  (fwd_rs2_sel),
    .bus_timeout  (bus_timeout),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit hits(input logic [4:0] s, input logic [4:0] rd, input logic we,
                              input logic ce);
    return (s != 0) && (s == rd) && (we == 1'b1) && (ce == 1'b1);
  endfunction

  function automatic void ref_sel(input logic [4:0] s, input bit en, output logic [1:0] sel,
                                  output bit hz);
    sel = 2'd0;
    hz  = 1'b0;
    if (en) begin
      if (hits(s, alu_rd, alu_rd_w_en, alu_clk_en)) begin
        if (alu_rd_valid) sel = 2'd1;
        else hz = 1'b1;
      end else if (hits(s, mem_rd, mem_rd_w_en, mem_clk_en)) begin
        if (mem_rd_valid) sel = 2'd2;
        else hz = 1'b1;
      end else if (hits(s, wb_rd, wb_rd_w_en, wb_clk_en)) begin
        sel = 2'd3;
      end
    end
  endfunction

  function automatic bit ref_lu_hz();
    logic [1:0] s1, s2;
    bit h1, h2;
    ref_sel(dec_rs1, 1'b1, s1, h1);
    ref_sel(dec_rs2, dec_use_rs2 == 1'b1, s2, h2);
    return (dec_valid == 1'b1) && (h1 || h2);
  endfunction

  // Compare every output against the model, away from the active edge.
  task automatic sample();
    logic [1:0] s1, s2;
    bit h1, h2, hz, r;
    @(negedge clk);
    r = (rst == 1'b1);
    ref_sel(dec_rs1, 1'b1, s1, h1);
    ref_sel(dec_rs2, dec_use_rs2 == 1'b1, s2, h2);
    hz = ref_lu_hz();
    check("force_stall", 32'(force_stall), r ? 0 : 32'(hz && !flush_in));
    check("mem_stall", 32'(mem_stall), r ? 0 : 32'(m_waiting && !dmem_ack));
    check("bus_timeout", 32'(bus_timeout), r ? 0 : 32'(m_aborting));
    check("busy", 32'(busy), r ? 0 : 32'(m_waiting || m_aborting || m_lu));
    check("fwd_rs1_sel", 32'(fwd_rs1_sel), r ? 0 : 32'(s1));
    check("fwd_rs2_sel", 32'(fwd_rs2_sel), r ? 0 : 32'(s2));
  endtask

  task automatic step();
    bit hz;
    hz = ref_lu_hz();
    @(posedge clk);
    if (rst) begin
      m_waiting = 0; m_aborting = 0; m_lu = 0; m_waited = 0;
    end else if (m_aborting) begin
      m_aborting = 0;
    end else if (m_waiting) begin
      if (dmem_ack) m_waiting = 0;
      else if (m_waited == TIMEOUT - 1) begin
        m_waiting = 0; m_aborting = 1;
      end else m_waited++;
    end else if (m_lu) begin
      if (flush_in || !hz) m_lu = 0;
    end else if (alu_mem_req && alu_clk_en) begin
      m_waiting = 1; m_waited = 0;
    end else if (hz) begin
      m_lu = 1;
    end
    #1;
  endtask

  task automatic clear_inputs();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs2 = 0;
    alu_clk_en = 0; alu_rd = 0; alu_rd_w_en = 0; alu_rd_valid = 0; alu_mem_req = 0;
    mem_clk_en = 0; mem_rd = 0; mem_rd_w_en = 0; mem_rd_valid = 0;
    wb_clk_en = 0; wb_rd = 0; wb_rd_w_en = 0;
    dmem_ack = 0; flush_in = 0;
  endtask

  task automatic issue_mem_req();
    alu_mem_req = 1; alu_clk_en = 1;
    sample(); step();
    alu_mem_req = 0; alu_clk_en = 0;
  endtask

  initial begin
    int cnt;
    clear_inputs();
    rst = 1;
    m_waiting = 0; m_aborting = 0; m_lu = 0; m_waited = 0;
    sample(); step();
    sample(); step();
    rst = 0;
    sample();
    check("reset_busy", 32'(busy), 0);
    step();

    // Load-use: lw x5 in ALU, add x6,x5,x1 in decode.
    dec_valid = 1; dec_rs1 = 5; dec_rs2 = 1; dec_use_rs2 = 1;
    alu_clk_en = 1; alu_rd = 5; alu_rd_w_en = 1; alu_rd_valid = 0;
    sample();
    check("lu_stall_now", 32'(force_stall), 1);
    step();
    alu_clk_en = 0; mem_clk_en = 1; mem_rd = 5; mem_rd_w_en = 1; mem_rd_valid = 1;
    sample();
    check("lu_fwd_mem", 32'(fwd_rs1_sel), 2);
    check("lu_released", 32'(force_stall), 0);
    step();
    clear_inputs();

    // ALU forward beats WB; x0 never matches.
    dec_valid = 1; dec_rs1 = 3;
    alu_clk_en = 1; alu_rd = 3; alu_rd_w_en = 1; alu_rd_valid = 1;
    wb_clk_en = 1; wb_rd = 3; wb_rd_w_en = 1;
    sample();
    check("fwd_alu_prio", 32'(fwd_rs1_sel), 1);
    step();
    dec_rs1 = 0; alu_rd = 0; wb_rd = 0;
    sample();
    check("x0_sel", 32'(fwd_rs1_sel), 0);
    check("x0_stall", 32'(force_stall), 0);
    step();
    clear_inputs();

    // Store with ack after 4 wait cycles.
    issue_mem_req();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      dmem_ack = (i == 4);
      sample();
      if (i == 0) check("store_busy", 32'(busy), 1);
      if (mem_stall) cnt++;
      if (bus_timeout) check("store_no_timeout", 32'(bus_timeout), 0);
      step();
    end
    dmem_ack = 0;
    check("store_stall_len", 32'(cnt), 4);

    // No ack: timeout after TIMEOUT stalled cycles, late ack discarded.
    issue_mem_req();
    cnt = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      sample();
      if (mem_stall) cnt++;
      step();
    end
    check("timeout_stall_len", 32'(cnt), TIMEOUT);
    dmem_ack = 1;
    sample();
    check("timeout_pulse", 32'(bus_timeout), 1);
    step();
    dmem_ack = 0;
    sample();
    check("timeout_pulse_end", 32'(bus_timeout), 0);
    check("after_abort_idle", 32'(busy), 0);
    step();

    // Flush during load-use stall.
    dec_valid = 1; dec_rs1 = 7;
    alu_clk_en = 1; alu_rd = 7; alu_rd_w_en = 1; alu_rd_valid = 0;
    sample(); step();
    flush_in = 1;
    sample();
    check("flush_stall_drop", 32'(force_stall), 0);
    step();
    clear_inputs();
    sample();
    check("flush_idle", 32'(busy), 0);
    step();

    // Reset in the middle of a memory wait.
    issue_mem_req();
    for (int i = 0; i < 3; i++) begin sample(); step(); end
    rst = 1;
    sample(); step();
    rst = 0;
    sample();
    check("rst_busy", 32'(busy), 0);
    check("rst_mem_stall", 32'(mem_stall), 0);
    step();
    dmem_ack = 1;
    sample();
    check("rst_ack_ignored", 32'(busy), 0);
    step();
    clear_inputs();

    // Randomized traffic with a small register range to force frequent matches.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      dec_valid    = 1'($urandom_range(0, 3) != 0);
      dec_rs1      = 5'($urandom_range(0, 3));
      dec_rs2      = 5'($urandom_range(0, 3));
      dec_use_rs2  = 1'($urandom);
      alu_clk_en   = 1'($urandom);
      alu_rd       = 5'($urandom_range(0, 3));
      alu_rd_w_en  = 1'($urandom);
      alu_rd_valid = 1'($urandom);
      alu_mem_req  = ($urandom_range(0, 7) == 0);
      mem_clk_en   = 1'($urandom);
      mem_rd       = 5'($urandom_range(0, 3));
      mem_rd_w_en  = 1'($urandom);
      mem_rd_valid = 1'($urandom);
      wb_clk_en    = 1'($urandom);
      wb_rd        = 5'($urandom_range(0, 3));
      wb_rd_w_en   = 1'($urandom);
      dmem_ack     = ($urandom_range(0, 9) == 0);
      flush_in     = ($urandom_range(0, 9) == 0);
      sample();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall scheduler for the ALU (execute) stage and the stages around it.
- Detects load-use and CSR-use hazards between decode and the ALU stage, and drives the ALU stage's force_stall input.
- Generates rs1/rs2 forwarding selects for the ALU operand muxes.
- Sequences the Mem-stage wait for data-memory load/store handshakes, including a bounded timeout.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles spent waiting for dmem_ack before aborting. Legal range 2..255.
- CNT_W, 8, width of the wait counter. Must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_rs1  in  5  decode rs1 address.
- dec_rs2  in  5  decode rs2 address.
- dec_use_rs2  in  1  instruction reads rs2 (R-type/branch/store).
- alu_clk_en  in  1  ALU stage output clk_en (instruction valid in ALU→Mem register).
- alu_rd  in  5  rd held in the ALU stage output register.
- alu_rd_w_en  in  1  ALU-stage instruction writes rd.
- alu_rd_valid  in  1  ALU-stage rd_wdata already valid (not load/CSR).
- alu_mem_req  in  1  stall_from_alu (load/store in ALU→Mem register).
- mem_clk_en, mem_rd, mem_rd_w_en, mem_rd_valid  in  1/5/1/1  same meaning for the Mem stage.
- wb_clk_en, wb_rd, wb_rd_w_en  in  1/5/1  same meaning for writeback (always valid data).
- dmem_ack  in  1  data memory completes the current access.
- flush_in  in  1  flush from the ALU stage (taken branch/jump).
- force_stall  out  1  to ALU stage force_stall; holds decode and ALU.
- mem_stall  out  1  holds Mem stage and all earlier stages.
- fwd_rs1_sel  out  2  0 = regfile, 1 = ALU rd_wdata, 2 = Mem result, 3 = WB result.
- fwd_rs2_sel  out  2  same encoding for rs2.
- bus_timeout  out  1  one-cycle pulse: memory access aborted.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset:
  - State IDLE, wait_cnt 0.
  - All outputs 0 while rst is high, including the combinational ones (gated by rst).
- Address matching: a source matches a stage when the address equals that stage's rd, rd != 0, rd_w_en = 1 and the stage's clk_en = 1. x0 never matches.
- Forwarding (combinational, zero latency):
  - Priority is ALU > Mem > WB; the youngest producer wins.
  - An ALU match selects 1 only if alu_rd_valid = 1. If alu_rd_valid = 0, the match is a hazard and the sel is driven 0.
  - A Mem match with mem_rd_valid = 0 is likewise a hazard.
  - rs2 sel is 0 whenever dec_use_rs2 = 0.
- Hazard: lu_hz = dec_valid & (an rs1 match, or an rs2 match with dec_use_rs2) against an ALU or Mem producer whose data is not yet valid.
- FSM states: IDLE, LU_STALL, MEM_WAIT, ABORT.
  - IDLE:
    - If alu_mem_req & alu_clk_en → MEM_WAIT, wait_cnt ← 0.
    - Else if lu_hz → LU_STALL.
  - LU_STALL:
    - force_stall = 1 (also asserted combinationally in the IDLE cycle where lu_hz is first seen).
    - → IDLE when lu_hz drops.
    - flush_in = 1 → IDLE immediately and force_stall deasserts the same cycle; flush takes priority.
  - MEM_WAIT:
    - mem_stall = 1, wait_cnt increments each cycle.
    - dmem_ack → IDLE; mem_stall drops in the ack cycle.
    - wait_cnt = MEM_TIMEOUT-1 without ack → ABORT.
    - flush_in is ignored; the memory transaction always completes.
  - ABORT:
    - bus_timeout = 1 for exactly one cycle, mem_stall = 0 → IDLE.
    - A late dmem_ack arriving in ABORT is discarded.
- Simultaneous events:
  - Memory request and lu_hz together → MEM_WAIT wins; force_stall remains asserted combinationally while lu_hz holds.
  - dmem_ack on the same cycle wait_cnt reaches MEM_TIMEOUT-1 → ack wins, no timeout.
- wait_cnt saturates and never wraps.
- rst mid-operation returns to IDLE on the next edge; any pending ack is dropped.

Decomposition:
- Shared package/header:
  - Forwarding select encodings: FWD_RF, FWD_ALU, FWD_MEM, FWD_WB.
  - FSM state typedef.
  - Default MEM_TIMEOUT.
- Sub-module fwd_match: single-source, 3-stage priority comparator, instantiated twice (rs1, rs2). Outputs sel and hazard.

Test Plan:
- lw x5 in ALU (alu_rd=5, rd_valid=0); decode add x6,x5,x1 → force_stall=1 same cycle. After the load moves to Mem with mem_rd_valid=1 → fwd_rs1_sel=2, stall=0.
- addi x3 in ALU (rd_valid=1) and x3 also in WB; decode rs1=3 → fwd_rs1_sel=1. Decode rs1=0 with alu_rd=0 → sel=0, no stall.
- Store issues, dmem_ack asserted after 4 cycles → mem_stall high exactly 4 cycles, busy=1 during the wait, bus_timeout=0.
- MEM_TIMEOUT=16, no ack → mem_stall high 16 cycles, then bus_timeout=1 for 1 cycle. Late ack ignored; state IDLE.
- Load-use stall active, flush_in=1 → force_stall=0 that cycle, FSM IDLE next cycle.
- rst=1 during MEM_WAIT at cycle 3 → next cycle all outputs 0, busy=0; a following ack produces no effect.
